// File: rtl/execute_mc_if.sv
// Handshake/bus bundle for the execute stage.
//   slave  : view used by execute_mc (register-read side in, EX/MEM side out)
//   master : view used by whoever drives the stage (upstream + downstream)
// Upstream : in_valid/in_ready, decoded controls, operands, jump offset, dest.
// Downstream: out_valid/out_ready, EX/MEM register contents, clear, flags.
interface execute_mc_if #(
  parameter int D_SIZE = 32,
  parameter int A_SIZE = 10
);
  logic              in_valid;
  logic              in_ready;
  logic              alu_en;
  logic              loadc_en;
  logic              jmp_sel;
  logic              jmpr_sel;
  logic              reg_we_in;
  logic              mem_we_in;
  logic              mem_re_in;
  logic [3:0]        alu_op;
  logic [D_SIZE-1:0] op1;
  logic [D_SIZE-1:0] op2;
  logic [A_SIZE-1:0] jmp_offset_in;
  logic [2:0]        dest_reg_in;

  logic              out_valid;
  logic              out_ready;
  logic [D_SIZE-1:0] result;
  logic [A_SIZE-1:0] addr_mem;
  logic [D_SIZE-1:0] dout_mem;
  logic              reg_we;
  logic              mem_we;
  logic              mem_re;
  logic              load_en;
  logic [2:0]        dest_reg;
  logic              jmp_sel_o;
  logic              jmpr_sel_o;
  logic [A_SIZE-1:0] jmp;
  logic [A_SIZE-1:0] jmp_offset;
  logic              clear;
  logic              flag_z;
  logic              flag_n;
  logic              flag_c;
  logic              flag_v;

  modport slave (
    input  in_valid, alu_en, loadc_en, jmp_sel, jmpr_sel,
           reg_we_in, mem_we_in, mem_re_in, alu_op, op1, op2,
           jmp_offset_in, dest_reg_in, out_ready,
    output in_ready, out_valid, result, addr_mem, dout_mem,
           reg_we, mem_we, mem_re, load_en, dest_reg,
           jmp_sel_o, jmpr_sel_o, jmp, jmp_offset, clear,
           flag_z, flag_n, flag_c, flag_v
  );

  modport master (
    output in_valid, alu_en, loadc_en, jmp_sel, jmpr_sel,
           reg_we_in, mem_we_in, mem_re_in, alu_op, op1, op2,
           jmp_offset_in, dest_reg_in, out_ready,
    input  in_ready, out_valid, result, addr_mem, dout_mem,
           reg_we, mem_we, mem_re, load_en, dest_reg,
           jmp_sel_o, jmpr_sel_o, jmp, jmp_offset, clear,
           flag_z, flag_n, flag_c, flag_v
  );
endinterface

// File: rtl/execute_mc.sv
// Execute stage: single-cycle ALU / load-constant / jump ops plus an iterative
// shift-add MUL that stalls upstream for D_SIZE cycles. Results land in a
// registered EX/MEM output with valid/ready handshake.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : execute_mc_if.slave (upstream op + controls in, EX/MEM register,
//              clear pulse and ADDF/SUBF status flags out)
module execute_mc #(
  parameter int D_SIZE = 32,
  parameter int A_SIZE = 10
) (
  input  logic        clk,
  input  logic        rst,
  execute_mc_if.slave bus
);

  localparam int SH_W  = $clog2(D_SIZE);
  localparam int CNT_W = SH_W + 1;

  typedef enum logic [3:0] {
    OP_ADD     = 4'd0,
    OP_ADDF    = 4'd1,
    OP_SUB     = 4'd2,
    OP_SUBF    = 4'd3,
    OP_AND     = 4'd4,
    OP_OR      = 4'd5,
    OP_XOR     = 4'd6,
    OP_NAND    = 4'd7,
    OP_NOR     = 4'd8,
    OP_NXOR    = 4'd9,
    OP_SHIFTR  = 4'd10,
    OP_SHIFTRA = 4'd11,
    OP_SHIFTL  = 4'd12,
    OP_MUL     = 4'd13
  } alu_op_e;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_e;

  state_e            state;

  // Multiplier working registers and the fields captured at MUL accept.
  logic [CNT_W-1:0]  mul_cnt;
  logic [D_SIZE-1:0] mul_a;
  logic [D_SIZE-1:0] mul_b;
  logic [D_SIZE-1:0] mul_acc;
  logic [D_SIZE-1:0] mul_step;
  logic [A_SIZE-1:0] m_addr;
  logic [D_SIZE-1:0] m_dout;
  logic              m_reg_we;
  logic              m_mem_we;
  logic              m_mem_re;
  logic [2:0]        m_dest;

  logic              out_free;
  logic              accept;
  logic              jump;
  logic              mul_start;

  logic [D_SIZE:0]   add_x;
  logic [D_SIZE:0]   sub_x;
  logic [SH_W-1:0]   sh;
  logic [D_SIZE-1:0] alu_res;
  logic              alu_flag_upd;
  logic              alu_c;
  logic              alu_v;
  logic [D_SIZE-1:0] sc_result;

  assign out_free     = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = (state == S_IDLE) && out_free;
  assign accept       = bus.in_valid && bus.in_ready;
  assign jump         = bus.jmp_sel || bus.jmpr_sel;
  assign mul_start    = accept && !jump && bus.alu_en &&
                        (alu_op_e'(bus.alu_op) == OP_MUL);
  assign mul_step     = mul_acc + (mul_b[0] ? mul_a : '0);

  // Single-cycle ALU; flags come from the D_SIZE+1 wide sum/difference.
  always_comb begin
    sh           = bus.op2[SH_W-1:0];
    add_x        = {1'b0, bus.op1} + {1'b0, bus.op2};
    sub_x        = {1'b0, bus.op1} - {1'b0, bus.op2};
    alu_res      = '0;
    alu_flag_upd = 1'b0;
    alu_c        = 1'b0;
    alu_v        = 1'b0;
    case (alu_op_e'(bus.alu_op))
      OP_ADD:  alu_res = add_x[D_SIZE-1:0];
      OP_ADDF: begin
        alu_res      = add_x[D_SIZE-1:0];
        alu_flag_upd = 1'b1;
        alu_c        = add_x[D_SIZE];
        alu_v        = (bus.op1[D_SIZE-1] == bus.op2[D_SIZE-1]) &&
                       (add_x[D_SIZE-1] != bus.op1[D_SIZE-1]);
      end
      OP_SUB:  alu_res = sub_x[D_SIZE-1:0];
      OP_SUBF: begin
        alu_res      = sub_x[D_SIZE-1:0];
        alu_flag_upd = 1'b1;
        alu_c        = sub_x[D_SIZE];
        alu_v        = (bus.op1[D_SIZE-1] != bus.op2[D_SIZE-1]) &&
                       (sub_x[D_SIZE-1] != bus.op1[D_SIZE-1]);
      end
      OP_AND:     alu_res = bus.op1 & bus.op2;
      OP_OR:      alu_res = bus.op1 | bus.op2;
      OP_XOR:     alu_res = bus.op1 ^ bus.op2;
      OP_NAND:    alu_res = ~(bus.op1 & bus.op2);
      OP_NOR:     alu_res = ~(bus.op1 | bus.op2);
      OP_NXOR:    alu_res = ~(bus.op1 ^ bus.op2);
      OP_SHIFTR:  alu_res = bus.op1 >> sh;
      OP_SHIFTRA: alu_res = $signed(bus.op1) >>> sh;
      OP_SHIFTL:  alu_res = bus.op1 << sh;
      default:    alu_res = '0;
    endcase

    if (jump)             sc_result = '0;
    else if (bus.alu_en)  sc_result = alu_res;
    else if (bus.loadc_en) sc_result = bus.op1;
    else                  sc_result = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      mul_cnt        <= '0;
      mul_a          <= '0;
      mul_b          <= '0;
      mul_acc        <= '0;
      m_addr         <= '0;
      m_dout         <= '0;
      m_reg_we       <= 1'b0;
      m_mem_we       <= 1'b0;
      m_mem_re       <= 1'b0;
      m_dest         <= '0;
      bus.out_valid  <= 1'b0;
      bus.result     <= '0;
      bus.addr_mem   <= '0;
      bus.dout_mem   <= '0;
      bus.reg_we     <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_re     <= 1'b0;
      bus.load_en    <= 1'b0;
      bus.dest_reg   <= '0;
      bus.jmp_sel_o  <= 1'b0;
      bus.jmpr_sel_o <= 1'b0;
      bus.jmp        <= '0;
      bus.jmp_offset <= '0;
      bus.clear      <= 1'b0;
      bus.flag_z     <= 1'b0;
      bus.flag_n     <= 1'b0;
      bus.flag_c     <= 1'b0;
      bus.flag_v     <= 1'b0;
    end else begin
      bus.clear <= accept && jump;
      // Drain by default; a completion below overrides this.
      if (bus.out_ready) bus.out_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (mul_start) begin
            state    <= S_MUL;
            mul_cnt  <= CNT_W'(D_SIZE);
            mul_a    <= bus.op1;
            mul_b    <= bus.op2;
            mul_acc  <= '0;
            m_addr   <= bus.op1[A_SIZE-1:0];
            m_dout   <= bus.op2;
            m_reg_we <= bus.reg_we_in;
            m_mem_we <= bus.mem_we_in;
            m_mem_re <= bus.mem_re_in;
            m_dest   <= bus.dest_reg_in;
          end else if (accept) begin
            bus.out_valid  <= 1'b1;
            bus.result     <= sc_result;
            bus.addr_mem   <= bus.op1[A_SIZE-1:0];
            bus.dout_mem   <= bus.op2;
            bus.reg_we     <= bus.reg_we_in;
            bus.mem_we     <= bus.mem_we_in;
            bus.mem_re     <= bus.mem_re_in;
            bus.load_en    <= bus.mem_re_in;
            bus.dest_reg   <= bus.dest_reg_in;
            bus.jmp_sel_o  <= bus.jmp_sel;
            bus.jmpr_sel_o <= bus.jmpr_sel;
            bus.jmp        <= jump ? bus.op2[A_SIZE-1:0] : '0;
            bus.jmp_offset <= bus.jmp_offset_in;
            if (!jump && bus.alu_en && alu_flag_upd) begin
              bus.flag_z <= (alu_res == '0);
              bus.flag_n <= alu_res[D_SIZE-1];
              bus.flag_c <= alu_c;
              bus.flag_v <= alu_v;
            end
          end
        end

        S_MUL: begin
          if (mul_cnt != CNT_W'(1)) begin
            mul_acc <= mul_step;
            mul_a   <= mul_a << 1;
            mul_b   <= mul_b >> 1;
            mul_cnt <= mul_cnt - CNT_W'(1);
          end else if (out_free) begin
            // Final step folds straight into the output register. If the
            // output is still occupied, hold here so nothing is overwritten.
            state          <= S_IDLE;
            mul_cnt        <= '0;
            bus.out_valid  <= 1'b1;
            bus.result     <= mul_step;
            bus.addr_mem   <= m_addr;
            bus.dout_mem   <= m_dout;
            bus.reg_we     <= m_reg_we;
            bus.mem_we     <= m_mem_we;
            bus.mem_re     <= m_mem_re;
            bus.load_en    <= m_mem_re;
            bus.dest_reg   <= m_dest;
            bus.jmp_sel_o  <= 1'b0;
            bus.jmpr_sel_o <= 1'b0;
            bus.jmp        <= '0;
            bus.jmp_offset <= '0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_mc.sv
module tb_execute_mc;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   edges;
  int   bad;

  execute_mc_if #(.D_SIZE(32), .A_SIZE(10)) bus ();

  execute_mc #(.D_SIZE(32), .A_SIZE(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ae, input logic lc, input logic js, input logic jr,
                       input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid      = 1'b1;
    bus.alu_en        = ae;
    bus.loadc_en      = lc;
    bus.jmp_sel       = js;
    bus.jmpr_sel      = jr;
    bus.alu_op        = op;
    bus.op1           = a;
    bus.op2           = b;
    bus.reg_we_in     = 1'b0;
    bus.mem_we_in     = 1'b0;
    bus.mem_re_in     = 1'b0;
    bus.dest_reg_in   = 3'd0;
    bus.jmp_offset_in = '0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    issue(0, 0, 0, 0, 4'd0, 32'h0, 32'h0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready",  bus.in_ready,  1'b1);
    chk("rst_result",    bus.result,    32'h0);
    chk("rst_clear",     bus.clear,     1'b0);
    chk("rst_flags",     {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}, 4'b0000);
    rst = 1'b0;
    tick();

    // ADDF wrap to zero, then AND leaves flags alone
    issue(1, 0, 0, 0, 4'd1, 32'hFFFF_FFFF, 32'h1);
    tick();
    chk("addf_result", bus.result, 32'h0);
    chk("addf_valid",  bus.out_valid, 1'b1);
    chk("addf_flags",  {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}, 4'b1010);
    issue(1, 0, 0, 0, 4'd4, 32'hF0F0, 32'hFF00);
    tick();
    chk("and_result", bus.result, 32'hF000);
    chk("and_valid",  bus.out_valid, 1'b1);
    chk("and_flags",  {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}, 4'b1010);

    // SUBF overflow and borrow
    issue(1, 0, 0, 0, 4'd3, 32'h8000_0000, 32'h1);
    tick();
    chk("subf1_result", bus.result, 32'h7FFF_FFFF);
    chk("subf1_flags",  {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}, 4'b0001);
    issue(1, 0, 0, 0, 4'd3, 32'h3, 32'h5);
    tick();
    chk("subf2_result", bus.result, 32'hFFFF_FFFE);
    chk("subf2_flags",  {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}, 4'b0110);

    // Reserved opcode: zero result, flags held
    issue(1, 0, 0, 0, 4'd14, 32'h1234, 32'h5678);
    tick();
    chk("rsv_result", bus.result, 32'h0);
    chk("rsv_flags",  {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}, 4'b0110);

    // Shifts
    issue(1, 0, 0, 0, 4'd11, 32'h8000_0000, 32'd4);
    tick();
    chk("shiftra", bus.result, 32'hF800_0000);
    issue(1, 0, 0, 0, 4'd12, 32'h1, 32'd33);
    tick();
    chk("shiftl_mask", bus.result, 32'h2);
    issue(1, 0, 0, 0, 4'd10, 32'h8000_0000, 32'd31);
    tick();
    chk("shiftr", bus.result, 32'h1);

    // Load constant, then a no-op with passthrough fields
    issue(0, 1, 0, 0, 4'd0, 32'hABCD, 32'h9);
    tick();
    chk("loadc", bus.result, 32'hABCD);
    issue(0, 0, 0, 0, 4'd0, 32'h12345, 32'h55);
    bus.reg_we_in   = 1'b1;
    bus.mem_re_in   = 1'b1;
    bus.dest_reg_in = 3'd5;
    tick();
    chk("nop_result",  bus.result,   32'h0);
    chk("nop_valid",   bus.out_valid, 1'b1);
    chk("nop_ctl",     {bus.reg_we, bus.mem_we, bus.mem_re, bus.load_en}, 4'b1011);
    chk("nop_dest",    bus.dest_reg, 3'd5);
    chk("nop_addr",    bus.addr_mem, 10'h345);
    chk("nop_dout",    bus.dout_mem, 32'h55);

    // Absolute jump wins over alu_en
    issue(1, 0, 1, 0, 4'd0, 32'h5, 32'h12345);
    bus.jmp_offset_in = 10'h3;
    bus.reg_we_in     = 1'b1;
    tick();
    chk("jmp_clear",  bus.clear,      1'b1);
    chk("jmp_addr",   bus.jmp,        10'h345);
    chk("jmp_off",    bus.jmp_offset, 10'h3);
    chk("jmp_sels",   {bus.jmp_sel_o, bus.jmpr_sel_o}, 2'b10);
    chk("jmp_result", bus.result,     32'h0);
    chk("jmp_regwe",  bus.reg_we,     1'b1);
    bus.in_valid = 1'b0;
    tick();
    chk("jmp_clear_end", bus.clear,     1'b0);
    chk("jmp_drained",   bus.out_valid, 1'b0);

    // Back-to-back relative jumps: one pulse each
    issue(0, 0, 0, 1, 4'd0, 32'h0, 32'h10);
    tick();
    chk("jr1_clear", bus.clear, 1'b1);
    chk("jr1_sels",  {bus.jmp_sel_o, bus.jmpr_sel_o}, 2'b01);
    issue(0, 0, 0, 1, 4'd0, 32'h0, 32'h20);
    tick();
    chk("jr2_clear", bus.clear, 1'b1);
    chk("jr2_jmp",   bus.jmp,   10'h20);
    bus.in_valid = 1'b0;
    tick();
    chk("jr_clear_end", bus.clear, 1'b0);

    // MUL 7*6: stall and exact latency
    issue(1, 0, 0, 0, 4'd13, 32'd7, 32'd6);
    bus.dest_reg_in = 3'd2;
    tick();
    bus.in_valid = 1'b0;
    edges = 0;
    bad   = 0;
    while (!bus.out_valid && edges < 40) begin
      if (bus.in_ready) bad++;
      tick();
      edges++;
    end
    chk("mul1_latency", edges,        32);
    chk("mul1_stall",   bad,          0);
    chk("mul1_result",  bus.result,   32'd42);
    chk("mul1_dest",    bus.dest_reg, 3'd2);
    chk("mul1_ready",   bus.in_ready, 1'b1);

    // MUL 0xFFFFFFFF*2, accepted while previous result drains
    issue(1, 0, 0, 0, 4'd13, 32'hFFFF_FFFF, 32'd2);
    tick();
    bus.in_valid = 1'b0;
    chk("mul2_drained", bus.out_valid, 1'b0);
    edges = 0;
    while (!bus.out_valid && edges < 40) begin
      tick();
      edges++;
    end
    chk("mul2_latency", edges,      32);
    chk("mul2_result",  bus.result, 32'hFFFF_FFFE);

    // Reset in the middle of a MUL aborts it
    issue(1, 0, 0, 0, 4'd13, 32'd3, 32'd3);
    tick();
    bus.in_valid = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    #1;
    chk("mulrst_valid", bus.out_valid, 1'b0);
    chk("mulrst_ready", bus.in_ready,  1'b1);
    #1;
    rst = 1'b0;
    bad = 0;
    repeat (40) begin
      tick();
      if (bus.out_valid) bad++;
    end
    chk("mulrst_no_out", bad, 0);

    // Backpressure with a second op waiting
    bus.out_ready = 1'b0;
    issue(1, 0, 0, 0, 4'd0, 32'd1, 32'd2);
    tick();
    chk("bp_first", bus.result, 32'd3);
    issue(1, 0, 0, 0, 4'd0, 32'd10, 32'd20);
    #1;
    chk("bp_not_ready", bus.in_ready, 1'b0);
    repeat (3) tick();
    chk("bp_hold_result", bus.result,    32'd3);
    chk("bp_hold_valid",  bus.out_valid, 1'b1);
    chk("bp_hold_ready",  bus.in_ready,  1'b0);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus.in_ready, 1'b1);
    tick();
    chk("bp_second",       bus.result,    32'd30);
    chk("bp_second_valid", bus.out_valid, 1'b1);
    bus.in_valid = 1'b0;
    tick();
    chk("bp_no_dup", bus.out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_mc.md
Name: execute_mc

Overview:
Parametrised execute stage for the pipelined core. It sits between register-read and memory, with registered EX/MEM outputs and valid/ready handshakes on both sides. Single-cycle ops are the full ALU set plus new registered flags. MUL is a new iterative multi-cycle op that stalls upstream.

Parameters:
D_SIZE, 32, data width; must be a power of two, at least 8.
A_SIZE, 10, address and jump width; A_SIZE <= D_SIZE.
SH_W, $clog2(D_SIZE), shift-amount width, derived.

Ports:
clk  in  1  clock; one clock
rst  in  1  reset, asynchronous and active-high
in_valid  in  1  upstream op valid
in_ready  out  1  stage can accept
alu_en  in  1  ALU op
loadc_en  in  1  load constant: result = op1
jmp_sel  in  1  absolute jump
jmpr_sel  in  1  relative jump
reg_we_in  in  1  passthrough
mem_we_in  in  1  passthrough
mem_re_in  in  1  passthrough
alu_op  in  4  0 ADD, 1 ADDF, 2 SUB, 3 SUBF, 4 AND, 5 OR, 6 XOR, 7 NAND, 8 NOR, 9 NXOR, 10 SHIFTR, 11 SHIFTRA, 12 SHIFTL, 13 MUL, 14-15 reserved
op1  in  D_SIZE  operand 1
op2  in  D_SIZE  operand 2
jmp_offset_in  in  A_SIZE  jump offset
dest_reg_in  in  3  destination register
out_valid  out  1  EX/MEM register valid
out_ready  in  1  downstream accepts
result  out  D_SIZE  registered result
addr_mem  out  A_SIZE  registered op1[A_SIZE-1:0]
dout_mem  out  D_SIZE  registered op2
reg_we, mem_we, mem_re, load_en  out  1 each  registered controls; load_en = mem_re
dest_reg  out  3  registered destination register
jmp_sel_o, jmpr_sel_o  out  1 each  registered jump selects
jmp  out  A_SIZE  registered op2[A_SIZE-1:0] on jump
jmp_offset  out  A_SIZE  registered jump offset
clear  out  1  one-cycle flush pulse to upstream stages
flag_z, flag_n, flag_c, flag_v  out  1 each  status flags

Behaviour:
- Reset: async to IDLE. Every output and register goes to 0, including out_valid, clear, flags and the multiplier counter. in_ready is 1 after reset, per the rule below. Reset during MUL aborts the op with no output.
- FSM: IDLE, MUL.
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- Accept occurs when in_valid && in_ready at a clock edge.
- Output register:
  - Loads on the completion edge and sets out_valid=1.
  - Clears out_valid when out_ready is high and no new completion arrives.
  - All outputs stay stable while out_valid && !out_ready.
- Priority at accept: jump > alu_en > loadc_en > none.
  - Jump: result=0.
  - None: result=0; passthrough fields are still registered and out_valid=1.
- Single-cycle ops: result is valid on the edge after accept (latency 1).
- Shift ops:
  - The shift amount is op2[SH_W-1:0]; upper bits are ignored.
  - SHIFTRA is a signed arithmetic right shift.
- Reserved alu_op values: result=0; flags unchanged.
- Flags update only on ADDF/SUBF completion, computed on the D_SIZE+1 extension; they hold otherwise.
  - Z = (result == 0).
  - N = result MSB.
  - C = carry out for ADDF; borrow (op1 < op2 unsigned) for SUBF.
  - V = signed overflow.
- MUL:
  - Accept latches op1 and op2 and moves IDLE->MUL with count=D_SIZE.
  - Each cycle runs one shift-add step on the op2 LSB and decrements count.
  - At count==1 the step loads the low D_SIZE bits of the product into result, sets out_valid, and returns to IDLE.
  - out_valid rises exactly D_SIZE edges after the accept edge.
  - in_ready=0 throughout MUL.
  - The output register drains during MUL, so it is empty at completion.
- Jump:
  - On accept, clear=1 for exactly one cycle (the edge after accept).
  - jmp, jmp_offset and the selects are registered with the output, and reg_we is passed as given.
  - Back-to-back jumps produce one pulse each.
- Back-to-back single-cycle ops with out_ready=1 sustain one op per cycle.

Test Plan:
- ADDF op1=0xFFFFFFFF, op2=1 -> next cycle result=0, Z=1, C=1, N=0, V=0. A following AND 0xF0F0,0xFF00 -> result=0xF000, flags unchanged.
- SUBF op1=0x80000000, op2=1 -> result=0x7FFFFFFF, V=1, C=0, N=0. SUBF 3,5 -> result=0xFFFFFFFE, C=1, N=1.
- SHIFTRA 0x80000000 by op2=4 -> 0xF8000000. SHIFTL 1 by op2=33 -> 2 (masked). SHIFTR 0x80000000 by 31 -> 1.
- MUL 7*6 -> in_ready=0 for 32 cycles, result=42 with out_valid exactly 32 edges after accept. MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE. rst pulsed at cycle 10 of a MUL -> out_valid=0, state IDLE, in_ready=1.
- Hold out_ready=0 with two ops queued: first result held stable, in_ready=0, second not accepted. Release -> first drains, second completes the next cycle, with no loss or duplication.
- jmp_sel with op2=0x12345, jmp_offset_in=0x3 -> clear high for one cycle, jmp=0x345, jmp_offset=3, jmp_sel_o=1. Jump with alu_en=1 -> jump wins, result=0.
